manch_de: RTL and testbench



---
 rtl/manch_de.sv | 185 ++++++++++++++++++
 tb/tb_manch_de.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/manch_de.sv
// manch_de: Manchester decoder with 16x oversampling.
// Recovers framed bytes (sync bit, 8 data bits MSB first, optional parity bit)
// from the mdi line and presents them on dout with a data_ready/rdn handshake.
// Handshake: data_ready rises when a byte is loaded into dout; a rising edge of
// the synchronised rdn strobe clears data_ready and ovr_err. A load while
// data_ready is still set (and no read edge that cycle) raises ovr_err.
// Optional feature macro: MANCH_DE_PARITY_EN (adds the even-parity bit and PAR state).
module manch_de (
    input  logic       clk16x,
    input  logic       rstn,
    input  logic       mdi,
    input  logic       rdn,
    output logic [7:0] dout,
    output logic       data_ready,
    output logic       cv_err,
    output logic       par_err,
    output logic       ovr_err,
    output logic [1:0] state_dbg
);

`ifdef MANCH_DE_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, DATA = 2'd2, PAR = 2'd3} state_t;
    logic [7:0] shreg;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, DATA = 2'd2} state_t;
    logic [6:0] shreg;
`endif

    state_t     state, state_nx;
    logic       mdi_m, mdi_s, mdi_h;
    logic       rdn_m, rdn_s, rdn_h;
    logic [3:0] cnt;
    logic [2:0] bit_idx;
    logic       samp_a, samp_b;
    logic       mdi_rise, rd_edge, eval, bit_ok;
    logic       shift_en, load, viol;
    logic [7:0] load_byte;

    assign mdi_rise  = mdi_s & ~mdi_h;
    assign rd_edge   = rdn_s & ~rdn_h;
    assign eval      = (cnt == 4'd15);
    assign bit_ok    = samp_a ^ samp_b;
    assign state_dbg = state;

`ifdef MANCH_DE_PARITY_EN
    // Parity mode: the byte is complete in shreg by the time the parity bit ends.
    assign load_byte = shreg;
`else
    // No parity: the load coincides with the last data bit, so merge it in here.
    assign load_byte = {shreg, samp_a};
`endif

    // Two-flop synchronisers plus one history flop for edge detection.
    always_ff @(posedge clk16x or negedge rstn) begin
        if (!rstn) begin
            {mdi_m, mdi_s, mdi_h} <= 3'b000;
            {rdn_m, rdn_s, rdn_h} <= 3'b111;
        end else begin
            {mdi_m, mdi_s, mdi_h} <= {mdi, mdi_m, mdi_s};
            {rdn_m, rdn_s, rdn_h} <= {rdn, rdn_m, rdn_s};
        end
    end

    // State register.
    always_ff @(posedge clk16x or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic: bits are judged only at the end of each bit period.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (mdi_rise) state_nx = SYNC;
            SYNC: if (eval) state_nx = (bit_ok && samp_a) ? DATA : IDLE;
            DATA: begin
                if (eval) begin
                    if (!bit_ok) state_nx = IDLE;
                    else if (bit_idx == 3'd7) begin
`ifdef MANCH_DE_PARITY_EN
                        state_nx = PAR;
`else
                        state_nx = IDLE;
`endif
                    end
                end
            end
`ifdef MANCH_DE_PARITY_EN
            PAR: if (eval) state_nx = IDLE;
`endif
            default: state_nx = IDLE;
        endcase
    end

    // Control outputs: shift a data bit, load the output register, or flag a violation.
    always_comb begin
        shift_en = 1'b0;
        load     = 1'b0;
        viol     = 1'b0;
        case (state)
            DATA: begin
                if (eval) begin
                    if (!bit_ok) viol = 1'b1;
                    else begin
                        shift_en = 1'b1;
`ifndef MANCH_DE_PARITY_EN
                        if (bit_idx == 3'd7) load = 1'b1;
`endif
                    end
                end
            end
`ifdef MANCH_DE_PARITY_EN
            PAR: begin
                if (eval) begin
                    if (!bit_ok) viol = 1'b1;
                    else         load = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    // Bit timing: cnt runs only inside a frame; samples at the middle of each half-bit.
    always_ff @(posedge clk16x or negedge rstn) begin
        if (!rstn) begin
            cnt     <= 4'd0;
            bit_idx <= 3'd0;
            samp_a  <= 1'b0;
            samp_b  <= 1'b0;
        end else begin
            if (state == IDLE) begin
                cnt     <= 4'd0;
                bit_idx <= 3'd0;
            end else begin
                cnt <= cnt + 4'd1;
                if (shift_en) bit_idx <= bit_idx + 3'd1;
            end
            if (cnt == 4'd4)  samp_a <= mdi_s;
            if (cnt == 4'd12) samp_b <= mdi_s;
        end
    end

    // Data shift register, MSB first.
    always_ff @(posedge clk16x or negedge rstn) begin
        if (!rstn) shreg <= '0;
`ifdef MANCH_DE_PARITY_EN
        else if (shift_en) shreg <= {shreg[6:0], samp_a};
`else
        else if (shift_en) shreg <= {shreg[5:0], samp_a};
`endif
    end

    // Host-side registers: a load overrides a same-cycle read for data_ready.
    always_ff @(posedge clk16x or negedge rstn) begin
        if (!rstn) begin
            dout       <= 8'h00;
            data_ready <= 1'b0;
            ovr_err    <= 1'b0;
            cv_err     <= 1'b0;
        end else begin
            cv_err <= viol;
            if (rd_edge) begin
                data_ready <= 1'b0;
                ovr_err    <= 1'b0;
            end
            if (load) begin
                dout       <= load_byte;
                data_ready <= 1'b1;
                if (data_ready && !rd_edge) ovr_err <= 1'b1;
            end
        end
    end

`ifdef MANCH_DE_PARITY_EN
    // Parity status of the byte in dout; samp_a holds the received parity bit at load.
    always_ff @(posedge clk16x or negedge rstn) begin
        if (!rstn)     par_err <= 1'b0;
        else if (load) par_err <= samp_a ^ (^shreg);
    end
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_manch_de.sv
// tb_manch_de: randomized and directed frames for manch_de, checked by a
// queue-based scoreboard fed from a frame-level reference model.
module tb_manch_de;

`ifdef MANCH_DE_PARITY_EN
  localparam int N_BITS = 10;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int N_BITS = 9;
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int W = 13;
  localparam logic [1:0] K_LOAD = 2'd1;
  localparam logic [1:0] K_CV   = 2'd2;

  logic       clk16x = 1'b0;
  logic       rstn   = 1'b0;
  logic       mdi    = 1'b0;
  logic       rdn    = 1'b1;
  logic [7:0] dout;
  logic       data_ready, cv_err, par_err, ovr_err;
  logic [1:0] state_dbg;

  manch_de dut (
    .clk16x     (clk16x),
    .rstn       (rstn),
    .mdi        (mdi),
    .rdn        (rdn),
    .dout       (dout),
    .data_ready (data_ready),
    .cv_err     (cv_err),
    .par_err    (par_err),
    .ovr_err    (ovr_err),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk16x = ~clk16x;

  int cyc = 0;
  always @(posedge clk16x) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           exp_t_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;

  // reference model of the host-visible registers
  logic [7:0] m_dout  = 8'h00;
  logic       m_ready = 1'b0;
  logic       m_ovr   = 1'b0;
  logic       m_par   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Frame-level model: outcome of a whole frame from its content.
  task automatic model_frame(input logic [7:0] data, input logic pbit, input int viol_bit, input int c);
    logic p;
    if (viol_bit == 0) return;
    if (viol_bit > 0) begin
      exp_q.push_back({K_CV, m_ovr, m_ready, m_par, m_dout});
      exp_t_q.push_back(c + 3 + 16 * (viol_bit + 1));
    end else begin
      p = PAR_EN ? ((^data) != pbit) : 1'b0;
      m_ovr   = m_ovr | m_ready;
      m_ready = 1'b1;
      m_dout  = data;
      m_par   = p;
      exp_q.push_back({K_LOAD, m_ovr, 1'b1, p, data});
      exp_t_q.push_back(c + 3 + 16 * N_BITS);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic half_bit(input logic v);
    mdi = v;
    repeat (8) @(negedge clk16x);
  endtask

  // viol_bit / rst_bit: frame bit index (0 = sync) to corrupt or to reset in; -1 = none
  task automatic send_frame(input logic [7:0] data, input logic pbit, input int viol_bit,
                            input logic viol_lvl, input int rst_bit);
    int   c;
    logic v;
    bit   aborted;
    aborted = 1'b0;
    @(negedge clk16x);
    c = cyc;
    for (int b = 0; b < N_BITS; b++) begin
      if (b == 0)      v = 1'b1;
      else if (b <= 8) v = data[8-b];
      else             v = pbit;
      if (b == viol_bit) begin
        half_bit(viol_lvl);
        half_bit(viol_lvl);
        break;
      end
      if (b == rst_bit) begin
        half_bit(v);
        rstn = 1'b0;
        #1;
        check("rst_mid_dout", dout, 8'h00);
        check("rst_mid_ready", data_ready, 1'b0);
        check("rst_mid_ovr", ovr_err, 1'b0);
        check("rst_mid_par", par_err, 1'b0);
        check("rst_mid_cv", cv_err, 1'b0);
        check("rst_mid_state", state_dbg, 2'd0);
        aborted = 1'b1;
        break;
      end
      half_bit(v);
      half_bit(~v);
    end
    mdi = 1'b0;
    if (aborted) begin
      repeat (4) @(negedge clk16x);
      rstn    = 1'b1;
      m_dout  = 8'h00;
      m_ready = 1'b0;
      m_ovr   = 1'b0;
      m_par   = 1'b0;
    end else begin
      model_frame(data, pbit, viol_bit, c);
    end
    repeat ($urandom_range(4, 20)) @(negedge clk16x);
  endtask

  task automatic read_byte();
    @(negedge clk16x);
    rdn = 1'b0;
    repeat ($urandom_range(1, 4)) @(negedge clk16x);
    rdn = 1'b1;
    repeat (2) @(negedge clk16x);
    check("read_before_clear", data_ready, m_ready);
    @(negedge clk16x);
    check("read_ready_clr", data_ready, 1'b0);
    check("read_ovr_clr", ovr_err, 1'b0);
    check("read_dout_hold", dout, m_dout);
    check("read_par_hold", par_err, m_par);
    m_ready = 1'b0;
    m_ovr   = 1'b0;
    repeat (2) @(negedge clk16x);
  endtask

  task automatic glitch();
    int c;
    @(negedge clk16x);
    c   = cyc;
    mdi = 1'b1;
    repeat (3) @(negedge clk16x);
    mdi = 1'b0;
    repeat (15) @(negedge clk16x);
    check("glitch_in_frame", (state_dbg != 2'd0), 1'b1);
    @(negedge clk16x);
    check("glitch_idle", state_dbg, 2'd0);
    check("glitch_ready", data_ready, m_ready);
    repeat (6) @(negedge clk16x);
  endtask

  // ---------------- monitor ----------------
  logic prev_dr  = 1'b0;
  logic prev_ovr = 1'b0;

  always @(negedge clk16x) begin
    logic [W-1:0] e;
    int           t;
    if (rstn && (cv_err || (data_ready && !prev_dr) || (ovr_err && !prev_ovr))) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_event: cv=%0b ready=%0b ovr=%0b dout=%0h at cycle %0d expected no event",
                 cv_err, data_ready, ovr_err, dout, cyc);
      end else begin
        e = exp_q.pop_front();
        t = exp_t_q.pop_front();
        check("event_time", cyc, t);
        check("event_cv", cv_err, (e[12:11] == K_CV));
        check("event_dout", dout, e[7:0]);
        check("event_par", par_err, e[8]);
        check("event_ready", data_ready, e[9]);
        check("event_ovr", ovr_err, e[10]);
      end
    end
    prev_dr  = data_ready;
    prev_ovr = ovr_err;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] d;
    logic       pb;
    int         vb;

    repeat (5) @(negedge clk16x);
    check("reset_dout", dout, 8'h00);
    check("reset_ready", data_ready, 1'b0);
    check("reset_cv", cv_err, 1'b0);
    check("reset_par", par_err, 1'b0);
    check("reset_ovr", ovr_err, 1'b0);
    check("reset_state", state_dbg, 2'd0);
    rstn = 1'b1;
    repeat (5) @(negedge clk16x);

    // clean 0xA5, correct parity
    send_frame(8'hA5, 1'b0, -1, 1'b0, -1);
    read_byte();
    // 0x3C with wrong parity bit
    send_frame(8'h3C, 1'b1, -1, 1'b0, -1);
    read_byte();
    // 0xFF with data bit 3 held high for a whole bit period
    send_frame(8'hFF, 1'b0, 4, 1'b1, -1);
    check("cv_ready_low", data_ready, 1'b0);
    check("cv_dout_keep", dout, 8'h3C);
    // short glitch on the idle line
    glitch();
    // overrun: two frames with no read
    send_frame(8'h11, 1'b0, -1, 1'b0, -1);
    send_frame(8'h22, 1'b0, -1, 1'b0, -1);
    check("ovr_dout", dout, 8'h22);
    check("ovr_flag", ovr_err, 1'b1);
    read_byte();
    // unread byte, then reset during data bit 5
    send_frame(8'h44, 1'b0, -1, 1'b0, -1);
    send_frame(8'h99, 1'b0, -1, 1'b0, 6);
    send_frame(8'h5A, 1'b0, -1, 1'b0, -1);
    read_byte();

    // randomized frames
    for (int i = 0; i < 30; i++) begin
      d  = 8'($urandom_range(0, 255));
      pb = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
      vb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, N_BITS - 1)) : -1;
      if ($urandom_range(0, 7) == 0) glitch();
      send_frame(d, pb, vb, 1'($urandom_range(0, 1)), -1);
      if (m_ovr || $urandom_range(0, 1) == 1) read_byte();
    end

    for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(negedge clk16x);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
